// File: rtl/ex_wb_sel_pipe.sv
// Registered NUM_IN-way writeback source select: 1-cycle latency, 2-entry skid so in_ready depends only on held state.
// Define EX_SEL_ERR_EN to add a sticky sel_err output flagging pushes with an out-of-range select.
module ex_wb_sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic [1:0]              occupancy
`ifdef EX_SEL_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_main_dat;
  logic [SEL_W-1:0]   r_main_src;
  logic [WIDTH-1:0]   r_skid_dat;
  logic [SEL_W-1:0]   r_skid_src;
  logic [WIDTH-1:0]   w_sel_word;
  logic               w_push;
  logic               w_pop;
  logic               w_ld_main_in;
  logic               w_ld_main_skid;
  logic               w_ld_skid;

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign occupancy = r_state;
  assign out_data  = r_main_dat;
  assign out_src   = r_main_src;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Selects with no matching source fall through to the zero default.
  always_comb begin
    w_sel_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        w_sel_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt  = S_ONE;
          w_ld_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && !w_pop) begin
          w_state_nxt = S_FULL;
          w_ld_skid   = 1'b1;
        end else if (w_push && w_pop) begin
          w_ld_main_in = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_state_nxt    = S_ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
    // Flush wins over any same-cycle push or pop; held data is left in place.
    if (flush) begin
      w_state_nxt    = S_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_main_dat <= '0;
      r_main_src <= '0;
      r_skid_dat <= '0;
      r_skid_src <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ld_main_in) begin
        r_main_dat <= w_sel_word;
        r_main_src <= in_sel;
      end else if (w_ld_main_skid) begin
        r_main_dat <= r_skid_dat;
        r_main_src <= r_skid_src;
      end
      if (w_ld_skid) begin
        r_skid_dat <= w_sel_word;
        r_skid_src <= in_sel;
      end
    end
  end

`ifdef EX_SEL_ERR_EN
  logic w_sel_oob;
  logic r_sel_err;

  assign w_sel_oob = (32'(in_sel) >= 32'(NUM_IN));
  assign sel_err   = r_sel_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel_err <= 1'b0;
    end else if (flush) begin
      r_sel_err <= 1'b0;
    end else if (w_push && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_wb_sel_pipe.sv
// Randomized and directed bench for ex_wb_sel_pipe (NUM_IN=3) against a 2-deep queue reference model.
module tb_ex_wb_sel_pipe;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  logic                    clk;
  logic                    reset;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flush;
  logic [1:0]              occupancy;
`ifdef EX_SEL_ERR_EN
  logic                    sel_err;
`endif

  ex_wb_sel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef EX_SEL_ERR_EN
    ,
    .sel_err   (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: FIFO of accepted words, capacity 2, plus sticky error flag.
  logic [WIDTH-1:0] mq_dat[$];
  logic [SEL_W-1:0] mq_src[$];
  logic             m_err = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq_dat.delete();
    mq_src.delete();
    m_err = 1'b0;
  endtask

  // One clock: drive, check in_ready before the edge, advance model, check outputs after.
  task automatic cyc(input logic v, input logic [SEL_W-1:0] sel,
                     input logic [NUM_IN*WIDTH-1:0] dat, input logic ordy, input logic fl);
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] word;
    in_valid  = v;
    in_sel    = sel;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
    #1;
    chk("in_ready", 64'(in_ready), 64'(mq_dat.size() < 2));
    push = v && (mq_dat.size() < 2);
    pop  = (mq_dat.size() != 0) && ordy;
    word = (int'(sel) < NUM_IN) ? dat[int'(sel)*WIDTH +: WIDTH] : '0;
    @(posedge clk);
    if (fl) begin
      mq_dat.delete();
      mq_src.delete();
      m_err = 1'b0;
    end else begin
      if (pop) begin
        void'(mq_dat.pop_front());
        void'(mq_src.pop_front());
      end
      if (push) begin
        mq_dat.push_back(word);
        mq_src.push_back(sel);
        if (int'(sel) >= NUM_IN) m_err = 1'b1;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(mq_dat.size() != 0));
    chk("occupancy", 64'(occupancy), 64'(mq_dat.size()));
    if (mq_dat.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(mq_dat[0]));
      chk("out_src", 64'(out_src), 64'(mq_src[0]));
    end
`ifdef EX_SEL_ERR_EN
    chk("sel_err", 64'(sel_err), 64'(m_err));
`endif
  endtask

  function automatic logic [NUM_IN*WIDTH-1:0] pack3(input logic [WIDTH-1:0] s0,
                                                    input logic [WIDTH-1:0] s1,
                                                    input logic [WIDTH-1:0] s2);
    return {s2, s1, s0};
  endfunction

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    in_data   = pack3(32'h1, 32'h2, 32'h3);
    out_ready = 1'b0;
    flush     = 1'b0;
    model_clear();

    // Reset held with a pending push.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
`ifdef EX_SEL_ERR_EN
    chk("rst_sel_err", 64'(sel_err), 64'd0);
`endif
    reset = 1'b1;

    cyc(1'b1, 2'd1, pack3(32'h0, 32'hDEADBEEF, 32'h0), 1'b1, 1'b0);
    chk("first_word", 64'(out_data), 64'hDEADBEEF);
    chk("first_src", 64'(out_src), 64'd1);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Fill with consumer stalled, third push refused, then drain in order.
    cyc(1'b1, 2'd0, pack3(32'h11, 32'h0, 32'h0), 1'b0, 1'b0);
    cyc(1'b1, 2'd2, pack3(32'h0, 32'h0, 32'h22), 1'b0, 1'b0);
    chk("full_occ", 64'(occupancy), 64'd2);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b1, 2'd1, pack3(32'h0, 32'h33, 32'h0), 1'b0, 1'b0);
    chk("hold_data", 64'(out_data), 64'h11);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("drain_second", 64'(out_data), 64'h22);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Streaming: one word per cycle, occupancy stays 1.
    for (int i = 1; i <= 8; i++) begin
      logic [SEL_W-1:0] s;
      s = SEL_W'(i % NUM_IN);
      cyc(1'b1, s, pack3(32'(i), 32'(i), 32'(i)), 1'b1, 1'b0);
      chk("stream_data", 64'(out_data), 64'(i));
    end
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Flush from FULL overrides a concurrent push.
    cyc(1'b1, 2'd0, pack3(32'hA1, 32'h0, 32'h0), 1'b0, 1'b0);
    cyc(1'b1, 2'd0, pack3(32'hA2, 32'h0, 32'h0), 1'b0, 1'b0);
    cyc(1'b1, 2'd0, pack3(32'hA3, 32'h0, 32'h0), 1'b1, 1'b1);
    chk("flush_valid", 64'(out_valid), 64'd0);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Out-of-range select yields zero with its select preserved.
    cyc(1'b1, 2'd3, pack3(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 1'b1, 1'b0);
    chk("oob_data", 64'(out_data), 64'd0);
    chk("oob_src", 64'(out_src), 64'd3);
    cyc(1'b1, 2'd0, pack3(32'h5, 32'h0, 32'h0), 1'b1, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b1);

    // Asynchronous reset while FULL.
    cyc(1'b1, 2'd1, pack3(32'h0, 32'hB1, 32'h0), 1'b0, 1'b0);
    cyc(1'b1, 2'd1, pack3(32'h0, 32'hB2, 32'h0), 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_occupancy", 64'(occupancy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    model_clear();
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(1'b1, 2'd2, pack3(32'h0, 32'h0, 32'hC1), 1'b0, 1'b0);
    chk("post_rst_occ", 64'(occupancy), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'hC1);
    cyc(1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 3)),
          {$urandom, $urandom, $urandom}, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 15) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_wb_sel_pipe.md
Name: ex_wb_sel_pipe

Overview:
- Parametrised, registered successor to the EX-stage writeback source select.
- Picks one of NUM_IN WIDTH-bit sources (PCSource, Mem, ALU, LO/HI, ...) using a select captured with the data.
- Registers the result behind a valid/ready handshake with a 2-entry skid buffer, so a stall in the writeback stage drops no selection.
- Sits between the EX/MEM datapath sources and the register-file write port.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_IN, 4, number of selectable sources (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  source index for this transfer.
- in_valid  input  1  producer offers in_data/in_sel.
- in_ready  output  1  block can accept this cycle.
- out_data  output  WIDTH  selected word, oldest entry.
- out_src  output  SEL_W  select value that produced out_data.
- out_valid  output  1  out_data/out_src valid.
- out_ready  input  1  consumer takes the entry this cycle.
- flush  input  1  synchronous discard of all held entries.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Reset (reset=0, asynchronous): state EMPTY; out_data=0, out_src=0, out_valid=0, occupancy=0; in_ready=1 while in reset and after release.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Selected word = source in_sel when in_sel < NUM_IN, otherwise all zeros. The word and in_sel are captured together on the push edge.
- Latency: a push into EMPTY gives out_valid=1 with that data on the next cycle. There is no combinational path from in_* to out_*.
- in_ready = (state != FULL), driven from registered state only. There is no combinational path from out_ready to in_ready.
- States:
  - EMPTY: push -> ONE.
  - ONE: push&!pop -> FULL (new entry goes to skid); pop&!push -> EMPTY; push&pop -> ONE (main entry replaced by new entry); neither -> ONE.
  - FULL: in_ready=0; pop -> ONE (skid moves to main); no pop -> FULL.
- Order preserved: out_data always presents the oldest entry.
- While out_valid=1 and out_ready=0, out_data and out_src hold stable.
- flush: at the next edge, state goes to EMPTY, out_valid=0 and occupancy=0. flush overrides push and pop in the same cycle; the pushed entry is discarded. out_data/out_src are not cleared.
- occupancy encodes EMPTY=0, ONE=1, FULL=2; it is a registered output.
- Reset asserted mid-transfer: all entries are dropped immediately. No output glitches to valid.

Optional Feature:
- Macro: EX_SEL_ERR_EN.
- Defined:
  - Adds output sel_err (1 bit, reset 0).
  - Sticky: set on any push with in_sel >= NUM_IN; cleared only by reset or flush.
  - The zero word is still forwarded.
- Undefined: sel_err port absent; out-of-range selects silently yield zero.

Test Plan:
- Reset with in_valid=1 -> out_valid=0, occupancy=0, in_ready=1; after release, push sel=1, src1=0xDEADBEEF -> next cycle out_data=0xDEADBEEF, out_src=1, out_valid=1.
- out_ready=0, push A(sel0=0x11) then B(sel2=0x22) -> occupancy=2, in_ready=0. Third push C is ignored. out_ready=1 -> 0x11 then 0x22 on consecutive cycles; C never appears.
- out_ready=1 with continuous pushes of 0x1..0x8 -> one word per cycle in order, occupancy stays 1, in_ready stays 1.
- Held in FULL, flush=1 together with in_valid=1 -> next cycle occupancy=0, out_valid=0; the flushed-cycle data never emerges.
- NUM_IN=3, push sel=3 -> out_data=0x00000000, out_src=3; with EX_SEL_ERR_EN, sel_err=1 and stays 1 until flush.
- Assert reset for one cycle while FULL -> out_valid drops asynchronously; the next push after release emerges alone with occupancy=1.
